// File: rtl/uart_rx_parity.sv
// -----------------------------------------------------------------------------
// uart_rx_parity
//   Serial receive front end of the UART. The asynchronous rx line is brought
//   into the UCLK domain through two flops, oversampled with the shared baud
//   tick s_tick, and decoded into frames:
//     start bit (false starts rejected at mid-bit), DATA_WIDTH data bits LSB
//     first, an optional parity bit, and STOP_BITS stop bits.
//   Each completed frame is presented to the RX FIFO write side as a one-cycle
//   rx_done_tick together with rx_dout, parity_err and frame_err, which all
//   hold until the next completed frame.
//
// Ports
//   UCLK         in   system clock, all logic on posedge
//   reset        in   synchronous, active-low reset
//   s_tick       in   one-UCLK pulse, OVERSAMPLE per bit period
//   rx           in   asynchronous serial input, idles high
//   rx_dout      out  last received data word
//   rx_done_tick out  one-cycle strobe per completed frame (RX FIFO write)
//   parity_err   out  parity mismatch on the last frame
//   frame_err    out  a stop bit was sampled low on the last frame
//   rx_busy      out  receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_parity #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_dout,
    output logic                  rx_done_tick,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    // Two-flop synchroniser; only rx_s_q is used by the decoder.
    logic rx_meta_q, rx_s_q;

    state_e                state_q, state_d;
    logic [SW-1:0]         s_q, s_d;
    logic [NW-1:0]         n_q, n_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  stop_err_q, stop_err_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  stop_flag;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        stop_cnt_d = stop_cnt_q;
        stop_err_d = stop_err_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_flag  = stop_err_q | ~rx_s_q;

        unique case (state_q)
            S_IDLE: begin
                // Line check runs every cycle, independent of s_tick.
                if (!rx_s_q) begin
                    state_d = S_START;
                    s_d     = '0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // Mid start bit: a line already back high was a glitch.
                        if (!rx_s_q) begin
                            state_d    = S_DATA;
                            s_d        = '0;
                            n_d        = '0;
                            stop_cnt_d = 1'b0;
                            stop_err_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) begin
                            state_d = PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        par_d   = rx_s_q;
                        s_d     = '0;
                        state_d = S_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (stop_cnt_q == STOP_LAST) begin
                            // Done edge: all four outputs update together.
                            dout_d  = shreg_q;
                            done_d  = 1'b1;
                            perr_d  = PAR_EN & (^shreg_q ^ par_q ^ PAR_ODD);
                            ferr_d  = stop_flag;
                            // A low stop bit may be a break; wait for idle.
                            state_d = stop_flag ? S_BREAK : S_IDLE;
                        end else begin
                            stop_cnt_d = stop_cnt_q + 1'b1;
                            stop_err_d = stop_flag;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge UCLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples values from before this edge, independent of statement order.
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            stop_err_q <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            stop_cnt_q <= stop_cnt_d;
            stop_err_q <= stop_err_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_parity
//   Self-checking bench for uart_rx_parity. Two instances share clock, reset
//   and baud tick: dut (defaults: 8 data bits, even parity, 1 stop bit) and
//   dut2 (no parity, 2 stop bits). Frames are driven bit by bit on the serial
//   lines; a monitor records every rx_done_tick strobe with its outputs and
//   cycle number, and each test task compares those records against values
//   derived from the frame contents.
// -----------------------------------------------------------------------------
module tb_uart_rx_parity;

    localparam int CLK_HALF   = 5;
    localparam int TICK_CLKS  = 4;
    localparam int OVERSAMPLE = 16;
    localparam int BIT        = TICK_CLKS * OVERSAMPLE;   // UCLK cycles per bit
    localparam int PARITY_ODD = 0;

    logic       UCLK, reset, s_tick, rx, rx2;
    logic [7:0] rx_dout, rx_dout2;
    logic       rx_done_tick, parity_err, frame_err, rx_busy;
    logic       rx_done_tick2, parity_err2, frame_err2, rx_busy2;

    uart_rx_parity #(
        .DATA_WIDTH(8), .OVERSAMPLE(OVERSAMPLE), .PARITY_EN(1),
        .PARITY_ODD(PARITY_ODD), .STOP_BITS(1)
    ) dut (
        .UCLK(UCLK), .reset(reset), .s_tick(s_tick), .rx(rx),
        .rx_dout(rx_dout), .rx_done_tick(rx_done_tick),
        .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    uart_rx_parity #(
        .DATA_WIDTH(8), .OVERSAMPLE(OVERSAMPLE), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(2)
    ) dut2 (
        .UCLK(UCLK), .reset(reset), .s_tick(s_tick), .rx(rx2),
        .rx_dout(rx_dout2), .rx_done_tick(rx_done_tick2),
        .parity_err(parity_err2), .frame_err(frame_err2), .rx_busy(rx_busy2)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } strobe_t;

    strobe_t q1[$];
    strobe_t q2[$];
    int      cyc;
    int      consec1, consec2;
    int      checks, failures;

    initial begin
        UCLK = 1'b0;
        forever #CLK_HALF UCLK = ~UCLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge UCLK);
            cyc++;
        end
    end

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (TICK_CLKS - 1) @(negedge UCLK);
            s_tick = 1'b1;
            @(negedge UCLK);
            s_tick = 1'b0;
        end
    end

    // Strobe monitor, sampling on the falling edge.
    initial begin
        bit prev1, prev2;
        strobe_t s;
        prev1 = 1'b0; prev2 = 1'b0; consec1 = 0; consec2 = 0;
        forever begin
            @(negedge UCLK);
            if (rx_done_tick === 1'b1) begin
                s.d = rx_dout; s.pe = parity_err; s.fe = frame_err; s.cyc = cyc;
                q1.push_back(s);
                if (prev1) consec1++;
            end
            if (rx_done_tick2 === 1'b1) begin
                s.d = rx_dout2; s.pe = parity_err2; s.fe = frame_err2; s.cyc = cyc;
                q2.push_back(s);
                if (prev2) consec2++;
            end
            prev1 = (rx_done_tick === 1'b1);
            prev2 = (rx_done_tick2 === 1'b1);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic good_parity(input logic [7:0] d);
        return 1'(($countones(d) + PARITY_ODD) % 2);
    endfunction

    // Parity error when data ones plus parity bit do not have the configured sense.
    function automatic logic exp_perr(input logic [7:0] d, input logic p);
        return 1'((($countones(d) + int'(p)) % 2) != PARITY_ODD);
    endfunction

    // ---------------- line drivers ----------------
    task automatic drive_bit(input int which, input logic b, input int nclk);
        if (which == 0) rx = b; else rx2 = b;
        repeat (nclk) @(negedge UCLK);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic pbit, input int nstop, input logic stop_val);
        drive_bit(which, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], BIT);
        if (has_par) drive_bit(which, pbit, BIT);
        for (int i = 0; i < nstop; i++) drive_bit(which, stop_val, BIT);
    endtask

    task automatic pop_strobe(input int which, output bit ok, output strobe_t s);
        ok = 1'b0;
        s.d = 'x; s.pe = 1'bx; s.fe = 1'bx; s.cyc = -1;
        if (which == 0 && q1.size() > 0) begin s = q1.pop_front(); ok = 1'b1; end
        if (which != 0 && q2.size() > 0) begin s = q2.pop_front(); ok = 1'b1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        rx = 1'b1; rx2 = 1'b1;
        repeat (3) @(negedge UCLK);
        checks++;
        if ({rx_dout, rx_done_tick, parity_err, frame_err, rx_busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got dout=%h done=%b pe=%b fe=%b busy=%b required all 0",
                     rx_dout, rx_done_tick, parity_err, frame_err, rx_busy);
        end
        checks++;
        if ({rx_dout2, rx_done_tick2, parity_err2, frame_err2, rx_busy2} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs2: got dout=%h done=%b busy=%b required all 0",
                     rx_dout2, rx_done_tick2, rx_busy2);
        end
        reset = 1'b1;
        repeat (2 * BIT) @(negedge UCLK);
        checks++;
        if (q1.size() + q2.size() != 0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got strobes=%0d busy=%b required 0 and 0",
                     q1.size() + q2.size(), rx_busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] data[2] = '{8'hAA, 8'h55};
        strobe_t s; bit ok;
        q1.delete();
        foreach (data[i]) begin
            send_frame(0, data[i], 1'b1, good_parity(data[i]), 1, 1'b1);
            drive_bit(0, 1'b1, BIT);
        end
        checks++;
        if (q1.size() != 2) begin
            failures++;
            $display("FAIL basic_count: got %0d strobes required 2", q1.size());
        end
        foreach (data[i]) begin
            pop_strobe(0, ok, s);
            checks++;
            if (!ok || {s.d, s.pe, s.fe} !== {data[i], 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL basic_frame%0d: got d=%h pe=%b fe=%b required d=%h pe=0 fe=0",
                         i, s.d, s.pe, s.fe, data[i]);
            end
        end
    endtask

    task automatic test_parity();
        logic p[2] = '{1'b0, 1'b1};
        strobe_t s; bit ok;
        q1.delete();
        foreach (p[i]) begin
            send_frame(0, 8'h07, 1'b1, p[i], 1, 1'b1);
            drive_bit(0, 1'b1, BIT);
            pop_strobe(0, ok, s);
            checks++;
            if (!ok || {s.d, s.pe, s.fe} !== {8'h07, exp_perr(8'h07, p[i]), 1'b0}) begin
                failures++;
                $display("FAIL parity_p%0d: got d=%h pe=%b fe=%b required d=07 pe=%b fe=0",
                         p[i], s.d, s.pe, s.fe, exp_perr(8'h07, p[i]));
            end
            checks++;
            if (parity_err !== exp_perr(8'h07, p[i])) begin
                failures++;
                $display("FAIL parity_hold_p%0d: got %b required %b", p[i], parity_err,
                         exp_perr(8'h07, p[i]));
            end
        end
    endtask

    task automatic test_break();
        strobe_t s; bit ok;
        q1.delete();
        send_frame(0, 8'h3C, 1'b1, good_parity(8'h3C), 1, 1'b0);
        drive_bit(0, 1'b0, 3 * BIT);
        checks++;
        if (q1.size() != 1 || rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL break_held: got strobes=%0d busy=%b required 1 and 1",
                     q1.size(), rx_busy);
        end
        drive_bit(0, 1'b1, 2 * BIT);
        checks++;
        if (q1.size() != 1 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL break_release: got strobes=%0d busy=%b required 1 and 0",
                     q1.size(), rx_busy);
        end
        pop_strobe(0, ok, s);
        checks++;
        if (!ok || {s.d, s.pe, s.fe} !== {8'h3C, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL break_frame: got d=%h pe=%b fe=%b required d=3c pe=0 fe=1",
                     s.d, s.pe, s.fe);
        end
        send_frame(0, 8'h81, 1'b1, good_parity(8'h81), 1, 1'b1);
        drive_bit(0, 1'b1, BIT);
        pop_strobe(0, ok, s);
        checks++;
        if (!ok || q1.size() != 0 || {s.d, s.pe, s.fe} !== {8'h81, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL break_recover: got d=%h pe=%b fe=%b required d=81 pe=0 fe=0",
                     s.d, s.pe, s.fe);
        end
    endtask

    task automatic test_glitch();
        strobe_t s; bit ok;
        q1.delete();
        drive_bit(0, 1'b0, 6 * TICK_CLKS);
        drive_bit(0, 1'b1, 2 * BIT);
        checks++;
        if (q1.size() != 0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: got strobes=%0d busy=%b required 0 and 0",
                     q1.size(), rx_busy);
        end
        send_frame(0, 8'h5A, 1'b1, good_parity(8'h5A), 1, 1'b1);
        drive_bit(0, 1'b1, BIT);
        pop_strobe(0, ok, s);
        checks++;
        if (!ok || {s.d, s.pe, s.fe} !== {8'h5A, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL glitch_next: got d=%h pe=%b fe=%b required d=5a pe=0 fe=0",
                     s.d, s.pe, s.fe);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'hF0;
        strobe_t s; bit ok;
        q1.delete();
        drive_bit(0, 1'b0, BIT);
        for (int i = 0; i < 3; i++) drive_bit(0, d[i], BIT);
        drive_bit(0, d[3], BIT / 2);
        reset = 1'b0;
        @(negedge UCLK);
        reset = 1'b1;
        rx = 1'b1;
        checks++;
        if ({rx_dout, rx_done_tick, parity_err, frame_err, rx_busy} !== 12'h000) begin
            failures++;
            $display("FAIL midreset_outputs: got dout=%h done=%b pe=%b fe=%b busy=%b required all 0",
                     rx_dout, rx_done_tick, parity_err, frame_err, rx_busy);
        end
        drive_bit(0, 1'b1, 2 * BIT);
        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL midreset_nostrobe: got %0d strobes required 0", q1.size());
        end
        send_frame(0, 8'h0F, 1'b1, good_parity(8'h0F), 1, 1'b1);
        drive_bit(0, 1'b1, BIT);
        pop_strobe(0, ok, s);
        checks++;
        if (!ok || {s.d, s.pe, s.fe} !== {8'h0F, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_next: got d=%h pe=%b fe=%b required d=0f pe=0 fe=0",
                     s.d, s.pe, s.fe);
        end
    endtask

    task automatic test_random();
        strobe_t exp_q[$];
        strobe_t e, s; bit ok;
        logic [7:0] d; logic p;
        q1.delete();
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~good_parity(d) : good_parity(d);
            e.d = d; e.pe = exp_perr(d, p); e.fe = 1'b0; e.cyc = 0;
            exp_q.push_back(e);
            send_frame(0, d, 1'b1, p, 1, 1'b1);
            drive_bit(0, 1'b1, $urandom_range(0, 2) * BIT + $urandom_range(0, 3));
        end
        drive_bit(0, 1'b1, BIT);
        checks++;
        if (q1.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d strobes required %0d", q1.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            pop_strobe(0, ok, s);
            checks++;
            if (!ok || {s.d, s.pe, s.fe} !== {exp_q[i].d, exp_q[i].pe, exp_q[i].fe}) begin
                failures++;
                $display("FAIL random_frame%0d: got d=%h pe=%b fe=%b required d=%h pe=%b fe=0",
                         i, s.d, s.pe, s.fe, exp_q[i].d, exp_q[i].pe);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data[2] = '{8'hC3, 8'h3C};
        strobe_t s[2]; bit ok;
        q2.delete();
        foreach (data[i]) send_frame(1, data[i], 1'b0, 1'b0, 2, 1'b1);
        drive_bit(1, 1'b1, 2 * BIT);
        checks++;
        if (q2.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d strobes required 2", q2.size());
        end
        foreach (data[i]) begin
            pop_strobe(1, ok, s[i]);
            checks++;
            if (!ok || {s[i].d, s[i].pe, s[i].fe} !== {data[i], 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL b2b_frame%0d: got d=%h pe=%b fe=%b required d=%h pe=0 fe=0",
                         i, s[i].d, s[i].pe, s[i].fe, data[i]);
            end
        end
        checks++;
        if (s[1].cyc - s[0].cyc != 11 * BIT) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d",
                     s[1].cyc - s[0].cyc, 11 * BIT);
        end
    endtask

    task automatic test_strobe_width();
        checks++;
        if (consec1 != 0 || consec2 != 0) begin
            failures++;
            $display("FAIL strobe_width: got %0d/%0d back-to-back strobe cycles required 0",
                     consec1, consec2);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        rx = 1'b1;
        rx2 = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        test_strobe_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
